matrix_operand_fetcher: RTL

- Upstream feeder for inner_product. For each output element (i,j) of C = A x B (N x N, 32-bit words), it reads row i of A and column j of B from two word-wide synchronous memories.
- It packs each operand into a 32*N-bit bus and presents row and column to inner_product under stb/ack handshakes.
- It walks all N*N (i,j) pairs in row-major order, j inner, and exports the current indices for the downstream result collector.

---
 rtl/matrix_operand_fetcher.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/matrix_operand_fetcher.sv
// Operand feeder for inner_product: for each (i,j) of C = A x B, reads row i of A
// and column j of B from synchronous memories and presents them under stb/ack.
module matrix_operand_fetcher #(
    parameter int unsigned number_of_elements = 4,
    parameter int unsigned addr_width         = 8,
    localparam int unsigned index_width       = (number_of_elements > 1) ? $clog2(number_of_elements) : 1,
    localparam int unsigned bus_width         = 32 * number_of_elements
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   a_rd_en,
    output logic [addr_width-1:0]  a_addr,
    input  logic [31:0]            a_rdata,
    output logic                   b_rd_en,
    output logic [addr_width-1:0]  b_addr,
    input  logic [31:0]            b_rdata,
    output logic [bus_width-1:0]   row,
    output logic                   row_o_stb,
    input  logic                   row_i_ack,
    output logic [bus_width-1:0]   column,
    output logic                   column_o_stb,
    input  logic                   column_i_ack,
    output logic [index_width-1:0] cur_i,
    output logic [index_width-1:0] cur_j
);

    localparam int unsigned n = number_of_elements;
    localparam logic [index_width-1:0] last_index = index_width'(n - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, NEXT, DONE} state_t;

    state_t                 state;
    logic [index_width-1:0] i;
    logic [index_width-1:0] j;
    logic [index_width-1:0] k;
    logic [addr_width-1:0]  row_base;
    logic                   cap_en;
    logic [index_width-1:0] cap_k;

    // Read data lags the enable by one cycle, so lane capture runs one cycle
    // behind issue through cap_en/cap_k; the last lane lands during DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            row_base     <= '0;
            cap_en       <= 1'b0;
            cap_k        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            a_rd_en      <= 1'b0;
            b_rd_en      <= 1'b0;
            a_addr       <= '0;
            b_addr       <= '0;
            row          <= '0;
            column       <= '0;
            row_o_stb    <= 1'b0;
            column_o_stb <= 1'b0;
            cur_i        <= '0;
            cur_j        <= '0;
        end else begin
            cap_en <= 1'b0;
            if (cap_en) begin
                row[32*int'(cap_k) +: 32]    <= a_rdata;
                column[32*int'(cap_k) +: 32] <= b_rdata;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        row_base <= '0;
                        busy     <= 1'b1;
                        a_rd_en  <= 1'b1;
                        b_rd_en  <= 1'b1;
                        a_addr   <= '0;
                        b_addr   <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    cap_en <= 1'b1;
                    cap_k  <= k;
                    if (k == last_index) begin
                        a_rd_en <= 1'b0;
                        b_rd_en <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        k      <= k + index_width'(1);
                        a_addr <= a_addr + addr_width'(1);
                        b_addr <= b_addr + addr_width'(n);
                    end
                end
                DRAIN: begin
                    row_o_stb    <= 1'b1;
                    column_o_stb <= 1'b1;
                    cur_i        <= i;
                    cur_j        <= j;
                    state        <= PRESENT;
                end
                PRESENT: begin
                    if (row_o_stb && row_i_ack) begin
                        row_o_stb <= 1'b0;
                    end
                    if (column_o_stb && column_i_ack) begin
                        column_o_stb <= 1'b0;
                    end
                    if ((!row_o_stb || row_i_ack) && (!column_o_stb || column_i_ack)) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    k <= '0;
                    if (j != last_index) begin
                        j       <= j + index_width'(1);
                        a_addr  <= row_base;
                        b_addr  <= addr_width'(j) + addr_width'(1);
                        a_rd_en <= 1'b1;
                        b_rd_en <= 1'b1;
                        state   <= FETCH;
                    end else if (i != last_index) begin
                        i        <= i + index_width'(1);
                        j        <= '0;
                        row_base <= row_base + addr_width'(n);
                        a_addr   <= row_base + addr_width'(n);
                        b_addr   <= '0;
                        a_rd_en  <= 1'b1;
                        b_rd_en  <= 1'b1;
                        state    <= FETCH;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
